// File: rtl/noise_cdf_gen.sv
// noise_cdf_gen: run-time loaded CDF-table noise generator; define NOISE_SAT_EN for a saturating sum
module noise_cdf_gen #(
  parameter int DEPTH  = 128,
  parameter int PROB_W = 64,
  parameter int DATA_W = 8,
  parameter int OFFSET = 63
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [$clog2(DEPTH+1)-1:0]    load_addr,
  input  logic [PROB_W-1:0]             load_data,
  output logic                          table_ready,
  output logic                          load_err,
  input  logic [PROB_W-1:0]             rnd_data,
  input  logic                          rnd_valid,
  input  logic signed [DATA_W-1:0]      sample_in,
  input  logic                          sample_valid,
  output logic signed [DATA_W-1:0]      sample_out,
  output logic signed [DATA_W-1:0]      noise_out,
  output logic                          out_valid,
  output logic                          sat_hit
);
  // address is one bit wider than the index when DEPTH is a power of two, so bad addresses stay visible
  localparam int AW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] DEP = AW'(DEPTH);
  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
  state_t                   state;
  logic [AW-1:0]            wr_cnt;
  logic [PROB_W-1:0]        cdf [DEPTH];
  logic                     addr_ok, accept, fire, emit, v1;
  logic [PROB_W-1:0]        rnd_r;
  logic signed [DATA_W-1:0] samp_r, noise_c, res_c;
  logic [AW-1:0]            cnt_c, idx_c;
`ifdef NOISE_SAT_EN
  logic [DATA_W:0]          sum_c;
  logic                     sat_c;
`endif
  assign addr_ok = load_addr < DEP;
  assign accept  = state == LOADING && load_valid && addr_ok && !load_start;
  assign fire    = state == READY && en && rnd_valid && sample_valid && !load_start;
  assign emit    = v1 && state == READY && !load_start;
  // table load control: counts accepted writes, flags bad addresses until the next load_start
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= EMPTY;
      wr_cnt      <= '0;
      table_ready <= 1'b0;
      load_err    <= 1'b0;
    end else if (load_start) begin
      state       <= LOADING;
      wr_cnt      <= '0;
      table_ready <= 1'b0;
      load_err    <= 1'b0;
    end else if (state == LOADING && load_valid) begin
      if (!addr_ok) load_err <= 1'b1;
      else begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == DEP - 1'b1) begin
          state       <= READY;
          table_ready <= 1'b1;
        end
      end
    end
  // table storage, deliberately not reset
  always_ff @(posedge clk)
    if (accept) cdf[load_addr[IW-1:0]] <= load_data;
  // stage 1: capture the joined random word and sample
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      v1     <= 1'b0;
      rnd_r  <= '0;
      samp_r <= '0;
    end else begin
      v1 <= fire;
      if (fire) begin
        rnd_r  <= rnd_data;
        samp_r <= sample_in;
      end
    end
  // index = number of entries not above the random word, so non-monotonic tables stay defined
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < DEPTH; i++) cnt_c = cnt_c + AW'(cdf[i] <= rnd_r);
    idx_c   = cnt_c == DEP ? DEP - 1'b1 : cnt_c;
    noise_c = DATA_W'(int'(idx_c) - OFFSET);
`ifdef NOISE_SAT_EN
    sum_c = {samp_r[DATA_W-1], samp_r} + {noise_c[DATA_W-1], noise_c};
    sat_c = sum_c[DATA_W] != sum_c[DATA_W-1];
    res_c = sat_c ? {sum_c[DATA_W], {(DATA_W-1){~sum_c[DATA_W]}}} : sum_c[DATA_W-1:0];
`else
    res_c = samp_r + noise_c;
`endif
  end
  // stage 2: register results; a flushed stage-1 entry leaves outputs untouched
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_valid  <= 1'b0;
      sample_out <= '0;
      noise_out  <= '0;
`ifdef NOISE_SAT_EN
      sat_hit    <= 1'b0;
`endif
    end else begin
      out_valid <= emit;
`ifdef NOISE_SAT_EN
      sat_hit   <= emit && sat_c;
`endif
      if (emit) begin
        sample_out <= res_c;
        noise_out  <= noise_c;
      end
    end
`ifndef NOISE_SAT_EN
  assign sat_hit = 1'b0;
`endif
endmodule

// File: tb/tb_noise_cdf_gen.sv
// tb_noise_cdf_gen: directed vector bench for noise_cdf_gen (DEPTH=128, PROB_W=64, DATA_W=8, OFFSET=63)
module tb_noise_cdf_gen;
`ifdef NOISE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic              clk = 1'b0;
  logic              rstn, en, load_start, load_valid, rnd_valid, sample_valid;
  logic [7:0]        load_addr;
  logic [63:0]       load_data, rnd_data;
  logic signed [7:0] sample_in, sample_out, noise_out;
  logic              table_ready, load_err, out_valid, sat_hit;
  int                n_vec = 0, n_err = 0;

  typedef struct {
    logic [63:0]       rnd;
    logic signed [7:0] smp;
    logic signed [7:0] nz;
    logic signed [7:0] wrap;
    logic signed [7:0] satv;
    logic              sh;
  } vec_t;
  vec_t vecs [12];

  noise_cdf_gen dut (
    .clk(clk), .rstn(rstn), .en(en), .load_start(load_start), .load_valid(load_valid),
    .load_addr(load_addr), .load_data(load_data), .table_ready(table_ready), .load_err(load_err),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_out(sample_out), .noise_out(noise_out), .out_valid(out_valid), .sat_hit(sat_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] cdfv(input int i);
    return i == 127 ? 64'hFFFF_FFFF_FFFF_FFFF : (64'(i + 1) << 57);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    en = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    rnd_valid = 1'b0; sample_valid = 1'b0; rnd_data = '0; sample_in = '0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic writes(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      load_valid = 1'b1; load_addr = 8'(i); load_data = cdfv(i);
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic drive(input int k);
    rnd_data = vecs[k].rnd; sample_in = vecs[k].smp; rnd_valid = 1'b1; sample_valid = 1'b1;
  endtask

  task automatic stop_drive();
    rnd_valid = 1'b0; sample_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{64'd0,                      8'sd10,   -8'sd63, -8'sd53,  -8'sd53,  1'b0};
    vecs[1]  = '{64'd64 << 57,               8'sd0,    8'sd1,   8'sd1,    8'sd1,    1'b0};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF,    8'sd100,  8'sd64,  -8'sd92,  8'sd127,  1'b1};
    vecs[3]  = '{64'd63 << 57,               -8'sd5,   8'sd0,   -8'sd5,   -8'sd5,   1'b0};
    vecs[4]  = '{(64'd10 << 57) - 64'd1,     -8'sd100, -8'sd54, 8'sd102,  -8'sd128, 1'b1};
    vecs[5]  = '{64'd127 << 57,              8'sd0,    8'sd64,  8'sd64,   8'sd64,   1'b0};
    vecs[6]  = '{64'd100 << 57,              8'sd27,   8'sd37,  8'sd64,   8'sd64,   1'b0};
    vecs[7]  = '{64'd1 << 57,                -8'sd1,   -8'sd62, -8'sd63,  -8'sd63,  1'b0};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF,    8'sd63,   8'sd64,  8'sd127,  8'sd127,  1'b0};
    vecs[9]  = '{64'd0,                      -8'sd65,  -8'sd63, -8'sd128, -8'sd128, 1'b0};
    vecs[10] = '{64'd0,                      -8'sd66,  -8'sd63, 8'sd127,  -8'sd128, 1'b1};
    vecs[11] = '{(64'd64 << 57) + 64'd5,     8'sd20,   8'sd1,   8'sd21,   8'sd21,   1'b0};
    idle();
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst table_ready", 64'(table_ready), 64'd0);
    chk("rst load_err", 64'(load_err), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst sample_out", 64'(sample_out), 64'd0);
    chk("rst noise_out", 64'(noise_out), 64'd0);
    chk("rst sat_hit", 64'(sat_hit), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    drive(0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("empty no out_valid", 64'(out_valid), 64'd0);
    end
    stop_drive();
    pulse_start();
    writes(0, 127);
    @(negedge clk);
    chk("127 writes not ready", 64'(table_ready), 64'd0);
    writes(127, 128);
    chk("128th write ready", 64'(table_ready), 64'd1);
    for (int j = 0; j < 14; j++) begin
      if (j >= 2) begin
        chk($sformatf("v%0d out_valid", j - 2), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d noise_out", j - 2), 64'(noise_out), 64'(vecs[j-2].nz));
        chk($sformatf("v%0d sample_out", j - 2), 64'(sample_out), SAT ? 64'(vecs[j-2].satv) : 64'(vecs[j-2].wrap));
        chk($sformatf("v%0d sat_hit", j - 2), 64'(sat_hit), 64'(SAT & vecs[j-2].sh));
      end
      if (j < 12) drive(j);
      else stop_drive();
      @(negedge clk);
    end
    chk("stream end out_valid", 64'(out_valid), 64'd0);
    chk("hold sample_out", 64'(sample_out), 64'(vecs[11].wrap));
    chk("hold noise_out", 64'(noise_out), 64'd1);
    rnd_valid = 1'b1;
    @(negedge clk);
    rnd_valid = 1'b0; sample_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      chk("join no out_valid", 64'(out_valid), 64'd0);
    end
    en = 1'b0;
    drive(0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("en low no out_valid", 64'(out_valid), 64'd0);
    end
    en = 1'b1;
    drive(0);
    @(negedge clk);
    en = 1'b0;
    stop_drive();
    @(negedge clk);
    chk("in-flight completes", 64'(out_valid), 64'd1);
    chk("in-flight noise", 64'(noise_out), -64'sd63);
    en = 1'b1;
    load_valid = 1'b1; load_addr = 8'd127; load_data = '0;
    @(negedge clk);
    load_valid = 1'b0;
    drive(0);
    @(negedge clk);
    stop_drive();
    @(negedge clk);
    chk("ready write ignored", 64'(noise_out), -64'sd63);
    chk("ready write out_valid", 64'(out_valid), 64'd1);
    drive(1);
    @(negedge clk);
    stop_drive();
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      chk("flush no out_valid", 64'(out_valid), 64'd0);
      chk("flush held noise", 64'(noise_out), -64'sd63);
      @(negedge clk);
    end
    chk("reload clears ready", 64'(table_ready), 64'd0);
    load_valid = 1'b1; load_addr = 8'd200; load_data = '0;
    @(negedge clk);
    load_valid = 1'b0;
    chk("bad addr load_err", 64'(load_err), 64'd1);
    writes(0, 127);
    chk("bad addr not counted", 64'(table_ready), 64'd0);
    writes(127, 128);
    chk("ready after bad addr", 64'(table_ready), 64'd1);
    chk("load_err sticky", 64'(load_err), 64'd1);
    pulse_start();
    chk("load_start clears err", 64'(load_err), 64'd0);
    writes(0, 128);
    chk("reloaded ready", 64'(table_ready), 64'd1);
    drive(2);
    @(negedge clk);
    stop_drive();
    rstn = 1'b0;
    #1;
    chk("midstream rst out_valid", 64'(out_valid), 64'd0);
    chk("midstream rst sample_out", 64'(sample_out), 64'd0);
    chk("midstream rst noise_out", 64'(noise_out), 64'd0);
    chk("midstream rst ready", 64'(table_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    drive(0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post rst no out_valid", 64'(out_valid), 64'd0);
    end
    stop_drive();
    pulse_start();
    writes(0, 60);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    writes(60, 128);
    chk("midload rst not ready", 64'(table_ready), 64'd0);
    pulse_start();
    writes(0, 128);
    chk("final ready", 64'(table_ready), 64'd1);
    drive(1);
    @(negedge clk);
    stop_drive();
    @(negedge clk);
    chk("final out_valid", 64'(out_valid), 64'd1);
    chk("final noise", 64'(noise_out), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
